// File: rtl/i2c_pkg.sv
// Shared I2C datapath definitions: frame FSM state encoding and bus-level constants.
package i2c_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_SHIFT = 2'b01;
    localparam state_t ST_ACK   = 2'b10;

    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam logic SDA_RELEASE = 1'b1;

endpackage

// File: rtl/shift_frame_if.sv
// Control/data bundle between the I2C byte FSM (master) and the frame shifter (slave).
interface shift_frame_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             load;
    logic             start;
    logic             abort;
    logic             dir;
    logic             shift_en;
    logic             serial_in;
    logic             ack_in;
    logic [WIDTH-1:0] data_in;
    logic             serial_out;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic             done;
    logic             ack_out;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output load, start, abort, dir, shift_en, serial_in, ack_in, data_in,
        input  serial_out, data_out, busy, done, ack_out, bit_cnt
    );

    modport slave (
        input  load, start, abort, dir, shift_en, serial_in, ack_in, data_in,
        output serial_out, data_out, busy, done, ack_out, bit_cnt
    );
endinterface

// File: rtl/shift_frame_core.sv
// Parametrised load/shift register; load wins over shift, reset clears the contents.
module shift_core #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             serial_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             tx_bit_o
);
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = data_i;
        end else if (shift_i) begin
            if (MSB_FIRST) data_d = {data_q[WIDTH-2:0], serial_i};
            else           data_d = {serial_i, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) data_q <= '0;
        else       data_q <= data_d;
    end

    assign data_o   = data_q;
    assign tx_bit_o = MSB_FIRST ? data_q[WIDTH-1] : data_q[0];
endmodule

// File: rtl/shift_frame.sv
// One I2C frame: WIDTH data bits in either direction plus the ACK slot, with bit count and done pulse.
module shift_frame
    import i2c_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic         clk,
    input  logic         asyn_rst,
    shift_frame_if.slave bus
);
    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_q, ack_d;
    logic             load_ok;
    logic             shift_ok;
    logic             tx_bit;
    logic [WIDTH-1:0] data;

    assign load_ok  = (state_q == ST_IDLE) && bus.load;
    assign shift_ok = (state_q == ST_SHIFT) && bus.shift_en && !bus.abort;

    shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk      (clk),
        .rst_i    (asyn_rst),
        .load_i   (load_ok),
        .shift_i  (shift_ok),
        .serial_i (bus.serial_in),
        .data_i   (bus.data_in),
        .data_o   (data),
        .tx_bit_o (tx_bit)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ack_d   = ack_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SHIFT;
                    dir_d   = bus.dir;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (bus.shift_en) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (bus.shift_en) begin
                    ack_d   = dir_q ? bus.ack_in : bus.serial_in;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (asyn_rst) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ack_q   <= I2C_NACK;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    // SDA drive is combinational so the ACK slot can follow ack_in without a cycle of lag.
    always_comb begin
        bus.serial_out = SDA_RELEASE;
        case (state_q)
            ST_SHIFT: bus.serial_out = dir_q ? SDA_RELEASE : tx_bit;
            ST_ACK:   bus.serial_out = dir_q ? bus.ack_in : SDA_RELEASE;
            default:  bus.serial_out = SDA_RELEASE;
        endcase
    end

    assign bus.data_out = data;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ack_out  = ack_q;
    assign bus.bit_cnt  = cnt_q;
endmodule

// File: doc/shift_frame.md
Name: shift_frame

Overview:
- Parametrised successor of the byte shifter used by the I2C master/slave datapath.
- Handles one complete I2C frame: WIDTH data bits in either direction plus the 9th ACK/NACK bit slot.
- Tracks its own bit count and signals completion, so the byte-level FSM only issues load/start and waits for done.
- Sits between the I2C control FSM, which supplies the per-bit shift_en strobe from SCL timing, and the SDA pad logic.

Parameters:
- WIDTH, 8, number of data bits per frame (2..32).
- MSB_FIRST, 1, 1: shift out/in MSB first (I2C); 0: LSB first.
- CNT_W, $clog2(WIDTH+1), width of bit_cnt output.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- asyn_rst  input  1  reset. One clock; reset is synchronous and active-high.
- load  input  1  load data_in into the shift register (honoured only when idle).
- start  input  1  begin a frame (honoured only when idle).
- abort  input  1  cancel the frame in progress, return to idle.
- dir  input  1  0: transmit (drive data, sample ACK); 1: receive (sample data, drive ACK). Sampled at start.
- shift_en  input  1  one-cycle bit strobe, one per SCL bit period.
- serial_in  input  1  sampled SDA.
- ack_in  input  1  ACK value to drive in receive mode (0 = ACK).
- data_in  input  WIDTH  parallel load data.
- serial_out  output  1  SDA drive value (1 = release).
- data_out  output  WIDTH  shift register contents.
- busy  output  1  high in SHIFT and ACK states.
- done  output  1  one-cycle pulse at frame end.
- ack_out  output  1  ACK bit captured or driven in the last frame (0 = ACK).
- bit_cnt  output  CNT_W  data bits shifted so far in the current frame.

Behaviour:
- Reset, synchronous, highest priority:
  - data_out=0, serial_out=1, busy=0, done=0, ack_out=1, bit_cnt=0, state=IDLE.
  - Reset mid-frame discards the frame; no done pulse.
- States: IDLE, SHIFT, ACK. All outputs are registered except serial_out, which is combinational from state/data/dir_q.
- IDLE:
  - load=1 → data <= data_in on the next edge.
  - start=1 → state<=SHIFT, dir_q<=dir, bit_cnt<=0, busy=1 on the next cycle.
  - load and start in the same cycle: both take effect; the frame uses data_in.
  - shift_en is ignored in IDLE.
  - serial_out=1.
- SHIFT:
  - serial_out = dir_q ? 1 : (MSB_FIRST ? data[WIDTH-1] : data[0]).
  - On shift_en: data <= MSB_FIRST ? {data[WIDTH-2:0],serial_in} : {serial_in,data[WIDTH-1:1]}, and bit_cnt++.
  - If bit_cnt==WIDTH-1 at that strobe, state<=ACK (bit_cnt becomes WIDTH).
- ACK:
  - serial_out = dir_q ? ack_in : 1.
  - On shift_en: ack_out <= dir_q ? ack_in : serial_in, done<=1 for exactly one cycle, busy<=0, state<=IDLE. data is unchanged in this state.
- load and start while busy are ignored, with no effect on data or state.
- abort, when not in reset:
  - Overrides shift_en in the same cycle: state<=IDLE, busy<=0, no done, data and ack_out retained, bit_cnt<=0.
  - In IDLE, abort has no effect and does not block a simultaneous load/start.
- done and start coincide only across consecutive cycles: start in the cycle done is high is accepted, because state is already IDLE.
- bit_cnt holds its value after the frame until the next start or abort.

Decomposition:
- Shared package i2c_pkg holds:
  - the state encoding typedef (IDLE/SHIFT/ACK);
  - constants I2C_ACK=1'b0, I2C_NACK=1'b1, SDA_RELEASE=1'b1.
- One natural sub-module: shift_core, the WIDTH/MSB_FIRST parametrised load/shift register, successor of the existing byte shifter. The FSM, counter and ACK handling live in shift_frame.

Test Plan:
- Transmit: WIDTH=8, MSB_FIRST=1, load+start with data_in=8'hA5, dir=0, then 9 shift_en strobes with serial_in=0 on the 9th. Required: serial_out sequence 1,0,1,0,0,1,0,1 then 1 (released); done pulses once; ack_out=0; busy low after done.
- Receive: dir=0→1, feed serial_in 1,1,0,0,1,0,1,0 with ack_in=0. Required: data_out=8'hCA; serial_out=0 during the ACK slot; ack_out=0; bit_cnt=8.
- LSB-first at WIDTH=12 (MSB_FIRST=0): transmit 12'h801. Required: first bit out 1, then ten 0s, then 1; done after the 13th strobe.
- Abort after 3 strobes. Required: busy=0 next cycle, no done, bit_cnt=0. A new start+load of 8'hFF is accepted immediately and completes normally.
- Reset asserted during the ACK state. Required: all outputs at reset values the next cycle, no done pulse. load/start asserted while busy changes nothing.
- Back-to-back frames: start asserted in the done cycle. Required: the second frame begins without an idle gap; two distinct done pulses.
